// File: rtl/bp_be_prefetch_scheduler_pkg.sv
// Shared types and helpers for the back-end prefetch scheduler.
package bp_be_prefetch_scheduler_pkg;

  typedef enum logic {e_pf_idle, e_pf_issue} bp_be_pf_state_e;

  localparam int unsigned bp_default_vaddr_width_lp  = 39;
  localparam int unsigned bp_default_stride_width_lp = 8;

  // Index width that stays legal for single-entry configurations.
  function automatic int unsigned bp_safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: combinational grant starting after the last winner,
// pointer advanced only when the grant is consumed (yumi_i).
module bsg_arb_round_robin
  import bp_be_prefetch_scheduler_pkg::*;
  #(parameter int unsigned width_p = 4
   ,localparam int unsigned lg_width_lp = bp_safe_clog2(width_p))
  (input  logic                   clk_i
  ,input  logic                   reset_i
  ,input  logic [width_p-1:0]     reqs_i
  ,output logic                   v_o
  ,output logic [lg_width_lp-1:0] tag_o
  ,input  logic                   yumi_i
  );

  logic [lg_width_lp-1:0] last_q, last_d, cand;

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    v_o   = 1'b0;
    tag_o = '0;
    cand  = '0;
    for (int k = width_p; k >= 1; k--) begin
      cand = last_q + lg_width_lp'(k);
      if (reqs_i[cand]) begin
        v_o   = 1'b1;
        tag_o = cand;
      end
    end
    last_d = (yumi_i & v_o) ? tag_o : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= '0;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/bp_be_prefetch_scheduler.sv
// Turns stride-detector confirms into a bounded burst of prefetches per stream
// and round-robins the active streams onto one valid/ready port.
module bp_be_prefetch_scheduler
  import bp_be_prefetch_scheduler_pkg::*;
  #(parameter int unsigned vaddr_width_p       = bp_default_vaddr_width_lp
   ,parameter int unsigned stride_width_p      = bp_default_stride_width_lp
   ,parameter int unsigned streams_p           = 4
   ,parameter int unsigned degree_p            = 4
   ,parameter int unsigned page_offset_width_p = 12)
  (input  logic                      clk_i
  ,input  logic                      reset_i
  ,input  logic                      confirm_v_i
  ,input  logic [vaddr_width_p-1:0]  confirm_addr_i
  ,input  logic [stride_width_p-1:0] confirm_stride_i
  ,input  logic                      demand_v_i
  ,input  logic                      flush_i
  ,output logic                      pf_v_o
  ,output logic [vaddr_width_p-1:0]  pf_addr_o
  ,input  logic                      pf_ready_i
  ,output logic                      busy_o
  );

  localparam int unsigned page_width_lp = vaddr_width_p - page_offset_width_p;
  localparam int unsigned rem_width_lp  = $clog2(degree_p + 1);
  localparam int unsigned idx_width_lp  = bp_safe_clog2(streams_p);
  localparam logic [rem_width_lp-1:0] degree_lp = rem_width_lp'(degree_p);

  typedef struct packed {
    logic                      v;
    logic [vaddr_width_p-1:0]  next_addr;
    logic [stride_width_p-1:0] stride;
    logic [page_width_lp-1:0]  page;
    logic [rem_width_lp-1:0]   remaining;
  } bp_be_pf_stream_s;

  function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  bp_be_pf_stream_s          tbl_q [streams_p];
  bp_be_pf_stream_s          tbl_d [streams_p];
  bp_be_pf_state_e           state_q, state_d;
  logic                      pf_v_q, pf_v_d;
  logic [vaddr_width_p-1:0]  pf_addr_q, pf_addr_d;
  logic [idx_width_lp-1:0]   lat_q, lat_d, vp_q, vp_d;
  logic                      kill_q, kill_d;

  logic                      conf_ok, hit_v, free_v, hit, alloc_we;
  logic [idx_width_lp-1:0]   hit_idx, free_idx, alloc_idx;
  logic [vaddr_width_p-1:0]  conf_target;
  logic [page_width_lp-1:0]  conf_page;

  logic                      hs, hs_live, hs_upd, hs_page_ok;
  logic [vaddr_width_p-1:0]  hs_addr;
  logic [rem_width_lp-1:0]   hs_rem;
  logic [streams_p-1:0]      elig, elig_eff;
  logic                      arb_v, launch;
  logic [idx_width_lp-1:0]   arb_tag;
  logic [vaddr_width_p-1:0]  launch_addr;

  // Confirm lookup and allocation, all against the pre-cycle table.
  always_comb begin
    conf_ok     = confirm_v_i & (confirm_stride_i != '0);
    conf_target = confirm_addr_i + sext(confirm_stride_i);
    conf_page   = confirm_addr_i[vaddr_width_p-1:page_offset_width_p];
    hit_v    = 1'b0;
    hit_idx  = '0;
    free_v   = 1'b0;
    free_idx = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (tbl_q[i].v && (tbl_q[i].stride == confirm_stride_i)
          && (tbl_q[i].next_addr == conf_target)) begin
        hit_v   = 1'b1;
        hit_idx = idx_width_lp'(i);
      end
      if (!tbl_q[i].v) begin
        free_v   = 1'b1;
        free_idx = idx_width_lp'(i);
      end
    end
    hit       = conf_ok & hit_v;
    alloc_we  = conf_ok & ~hit_v;
    alloc_idx = free_v ? free_idx : vp_q;
    vp_d      = vp_q;
    if (alloc_we && !free_v)
      vp_d = (vp_q == idx_width_lp'(streams_p - 1)) ? '0 : vp_q + 1'b1;
  end

  // Handshake effect on the latched entry. Arbitration sees the post-handshake
  // view of that entry so a back-to-back relaunch never reuses a stale address.
  always_comb begin
    hs         = (state_q == e_pf_issue) & pf_v_q & pf_ready_i;
    hs_live    = hs & ~kill_q;
    hs_upd     = hs_live & ~(alloc_we & (alloc_idx == lat_q));
    hs_addr    = tbl_q[lat_q].next_addr + sext(tbl_q[lat_q].stride);
    hs_rem     = tbl_q[lat_q].remaining - rem_width_lp'(1);
    hs_page_ok = hs_addr[vaddr_width_p-1:page_offset_width_p] == tbl_q[lat_q].page;
    for (int i = 0; i < streams_p; i++)
      elig[i] = tbl_q[i].v & (tbl_q[i].remaining != '0);
    elig_eff = elig;
    if (hs_live) elig_eff[lat_q] = hs_page_ok & (hs_rem != '0);
  end

  bsg_arb_round_robin #(.width_p(streams_p)) arb
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.reqs_i  (elig_eff)
    ,.v_o     (arb_v)
    ,.tag_o   (arb_tag)
    ,.yumi_i  (launch)
    );

  assign launch_addr = (hs_live && (arb_tag == lat_q)) ? hs_addr : tbl_q[arb_tag].next_addr;

  always_comb begin
    state_d   = state_q;
    pf_v_d    = pf_v_q;
    pf_addr_d = pf_addr_q;
    launch    = 1'b0;
    case (state_q)
      e_pf_idle: begin
        if (arb_v && !demand_v_i) launch = 1'b1;
      end
      e_pf_issue: begin
        if (hs) begin
          if (arb_v && !demand_v_i) launch = 1'b1;
          else begin
            state_d = e_pf_idle;
            pf_v_d  = 1'b0;
          end
        end
      end
      default: state_d = e_pf_idle;
    endcase
    if (launch) begin
      state_d   = e_pf_issue;
      pf_v_d    = 1'b1;
      pf_addr_d = launch_addr;
    end
    if (flush_i) begin
      state_d   = e_pf_idle;
      pf_v_d    = 1'b0;
      pf_addr_d = '0;
      launch    = 1'b0;
    end

    // A replaced in-flight entry must not receive that request's update.
    lat_d  = lat_q;
    kill_d = kill_q;
    if (launch) begin
      lat_d  = arb_tag;
      kill_d = alloc_we && (alloc_idx == arb_tag);
    end else if ((state_q == e_pf_issue) && alloc_we && (alloc_idx == lat_q)) begin
      kill_d = 1'b1;
    end
    if (flush_i) kill_d = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < streams_p; i++) begin
      tbl_d[i] = tbl_q[i];
      if (hit && (hit_idx == idx_width_lp'(i))) tbl_d[i].remaining = degree_lp;
      if (hs_upd && (lat_q == idx_width_lp'(i))) begin
        tbl_d[i].next_addr = hs_addr;
        if (hit && (hit_idx == idx_width_lp'(i))) begin
          tbl_d[i].remaining = degree_lp;
          tbl_d[i].v         = hs_page_ok;
        end else begin
          tbl_d[i].remaining = hs_rem;
          tbl_d[i].v         = hs_page_ok & (hs_rem != '0);
        end
      end
      if (alloc_we && (alloc_idx == idx_width_lp'(i))) begin
        tbl_d[i].v         = conf_target[vaddr_width_p-1:page_offset_width_p] == conf_page;
        tbl_d[i].next_addr = conf_target;
        tbl_d[i].stride    = confirm_stride_i;
        tbl_d[i].page      = conf_page;
        tbl_d[i].remaining = degree_lp;
      end
      if (flush_i) tbl_d[i].v = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_pf_idle;
      pf_v_q    <= 1'b0;
      pf_addr_q <= '0;
      lat_q     <= '0;
      kill_q    <= 1'b0;
      vp_q      <= '0;
      for (int i = 0; i < streams_p; i++) tbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pf_v_q    <= pf_v_d;
      pf_addr_q <= pf_addr_d;
      lat_q     <= lat_d;
      kill_q    <= kill_d;
      vp_q      <= vp_d;
      tbl_q     <= tbl_d;
    end
  end

  assign pf_v_o    = pf_v_q;
  assign pf_addr_o = pf_addr_q;
  assign busy_o    = (|elig) | pf_v_q;

endmodule
